// File: rtl/imem_arbiter_if.sv
// Request, response and SRAM-side signals of the instruction-memory arbiter.
// The arbiter sits on the slave modport; requesters and the SRAM sit on master.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    // Fetch port
    logic                  i_f_req;
    logic [31:0]           i_f_addr;
    logic                  o_f_gnt;
    logic                  o_f_rvalid;
    logic [31:0]           o_f_rdata;

    // Loader/debug port
    logic                  i_l_req;
    logic                  i_l_we;
    logic [3:0]            i_l_size;
    logic [31:0]           i_l_addr;
    logic [31:0]           i_l_wdata;
    logic                  i_l_lock;
    logic                  o_l_gnt;
    logic                  o_l_rvalid;
    logic [31:0]           o_l_rdata;

    // SRAM port
    logic [ADDR_WIDTH-3:0] o_mem_addr;
    logic [31:0]           o_mem_wdata;
    logic [3:0]            o_mem_size;
    logic                  o_mem_read;
    logic                  o_mem_write;
    logic [31:0]           i_mem_rdata;

    logic                  o_busy;

    modport slave (
        input  i_f_req, i_f_addr,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        input  i_l_req, i_l_we, i_l_size, i_l_addr, i_l_wdata, i_l_lock,
        output o_l_gnt, o_l_rvalid, o_l_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_size, o_mem_read, o_mem_write,
        input  i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_f_req, i_f_addr,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        output i_l_req, i_l_we, i_l_size, i_l_addr, i_l_wdata, i_l_lock,
        input  o_l_gnt, o_l_rvalid, o_l_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_size, o_mem_read, o_mem_write,
        output i_mem_rdata,
        input  o_busy
    );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port instruction SRAM arbiter: fetch vs loader, round-robin on conflict,
// combinational grant, single-cycle pipelined read/write response.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input logic           i_clk,
    input logic           i_rst_n,
    imem_arbiter_if.slave bus
);

    localparam int unsigned WordAw = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        RspIdle = 2'd0,
        RspF    = 2'd1,
        RspLr   = 2'd2,
        RspLw   = 2'd3
    } rsp_e;

    rsp_e              rsp_q, rsp_d;
    logic              last_l_q, last_l_d;
    logic              f_elig;
    logic              f_win, l_win;
    logic [WordAw-1:0] f_word, l_word;

    // Address bits outside the SRAM window and the byte offset are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_f_addr[31:ADDR_WIDTH], bus.i_f_addr[1:0],
                                bus.i_l_addr[31:ADDR_WIDTH], bus.i_l_addr[1:0]};

    assign f_word = bus.i_f_addr[ADDR_WIDTH-1:2];
    assign l_word = bus.i_l_addr[ADDR_WIDTH-1:2];

    // Arbitration; held at zero during reset so every output reads 0.
    always_comb begin
        f_elig = bus.i_f_req & ~bus.i_l_lock;
        f_win  = 1'b0;
        l_win  = 1'b0;
        if (i_rst_n) begin
            if (f_elig && bus.i_l_req) begin
                f_win = last_l_q;
                l_win = ~last_l_q;
            end else begin
                f_win = f_elig;
                l_win = bus.i_l_req;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_q    <= RspIdle;
            last_l_q <= 1'b1;
        end else begin
            rsp_q    <= rsp_d;
            last_l_q <= last_l_d;
        end
    end

    // Next-state logic
    always_comb begin
        rsp_d    = RspIdle;
        last_l_d = last_l_q;
        if (f_win) begin
            rsp_d    = RspF;
            last_l_d = 1'b0;
        end else if (l_win) begin
            rsp_d    = bus.i_l_we ? RspLw : RspLr;
            last_l_d = 1'b1;
        end
    end

    // Output logic: request side from the winner, response side from rsp_q.
    always_comb begin
        bus.o_f_gnt     = f_win;
        bus.o_l_gnt     = l_win;
        bus.o_mem_read  = 1'b0;
        bus.o_mem_write = 1'b0;
        bus.o_mem_size  = 4'h0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = 32'h0;
        if (f_win) begin
            bus.o_mem_read = 1'b1;
            bus.o_mem_size = 4'hF;
            bus.o_mem_addr = f_word;
        end else if (l_win) begin
            bus.o_mem_read  = ~bus.i_l_we;
            bus.o_mem_write = bus.i_l_we;
            bus.o_mem_size  = bus.i_l_we ? bus.i_l_size : 4'hF;
            bus.o_mem_addr  = l_word;
            bus.o_mem_wdata = bus.i_l_wdata;
        end

        bus.o_f_rvalid = 1'b0;
        bus.o_f_rdata  = 32'h0;
        bus.o_l_rvalid = 1'b0;
        bus.o_l_rdata  = 32'h0;
        unique case (rsp_q)
            RspF: begin
                bus.o_f_rvalid = 1'b1;
                bus.o_f_rdata  = bus.i_mem_rdata;
            end
            RspLr: begin
                bus.o_l_rvalid = 1'b1;
                bus.o_l_rdata  = bus.i_mem_rdata;
            end
            RspLw:   bus.o_l_rvalid = 1'b1;
            default: ;
        endcase
        bus.o_busy = (rsp_q != RspIdle);
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: SRAM model, reference model with per-cycle
// comparison, and literal checks on the documented scenarios.
module tb_imem_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned Words = 1 << (AW - 2);

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    imem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    imem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return {16'hC0DE, i[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: one-cycle read latency, byte-enabled writes.
    logic [31:0] sram [Words];
    logic [31:0] mem_rdata_q;
    assign bus.i_mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (bus.o_mem_read) mem_rdata_q <= sram[bus.o_mem_addr];
        if (bus.o_mem_write) begin
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_size[b]) sram[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
        end
    end

    // Reference model: who may win, who won last, what is owed next cycle.
    logic [31:0] shadow [Words];
    bit          m_last_l;
    int          m_pend;        // 0 none, 1 fetch, 2 loader read, 3 loader write
    logic [31:0] m_pend_data;

    always @(negedge clk) begin
        bit          f_ok, l_ok;
        int          win;       // 0 none, 1 fetch, 2 loader
        int          w;
        logic        e_read, e_write;
        logic [3:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        if (!rst_n) begin
            chk("rst_f_gnt", bus.o_f_gnt, 0);
            chk("rst_l_gnt", bus.o_l_gnt, 0);
            chk("rst_mem_read", bus.o_mem_read, 0);
            chk("rst_mem_write", bus.o_mem_write, 0);
            chk("rst_mem_size", bus.o_mem_size, 0);
            chk("rst_mem_addr", bus.o_mem_addr, 0);
            chk("rst_mem_wdata", bus.o_mem_wdata, 0);
            chk("rst_f_rvalid", bus.o_f_rvalid, 0);
            chk("rst_f_rdata", bus.o_f_rdata, 0);
            chk("rst_l_rvalid", bus.o_l_rvalid, 0);
            chk("rst_l_rdata", bus.o_l_rdata, 0);
            chk("rst_busy", bus.o_busy, 0);
            m_last_l = 1'b1;
            m_pend   = 0;
        end else begin
            f_ok = bus.i_f_req && !bus.i_l_lock;
            l_ok = bus.i_l_req;
            if (f_ok && l_ok) win = m_last_l ? 1 : 2;
            else if (f_ok)    win = 1;
            else if (l_ok)    win = 2;
            else              win = 0;

            e_read = 0; e_write = 0; e_size = 0; e_addr = 0; e_wdata = 0;
            if (win == 1) begin
                e_read = 1; e_size = 4'hF;
                e_addr = (bus.i_f_addr % (1 << AW)) / 4;
            end else if (win == 2) begin
                e_read  = !bus.i_l_we;
                e_write = bus.i_l_we;
                e_size  = bus.i_l_we ? bus.i_l_size : 4'hF;
                e_addr  = (bus.i_l_addr % (1 << AW)) / 4;
                e_wdata = bus.i_l_wdata;
            end

            chk("f_gnt", bus.o_f_gnt, win == 1);
            chk("l_gnt", bus.o_l_gnt, win == 2);
            chk("mem_read", bus.o_mem_read, e_read);
            chk("mem_write", bus.o_mem_write, e_write);
            chk("mem_size", bus.o_mem_size, e_size);
            chk("mem_addr", bus.o_mem_addr, e_addr);
            chk("mem_wdata", bus.o_mem_wdata, e_wdata);
            chk("f_rvalid", bus.o_f_rvalid, m_pend == 1);
            chk("f_rdata", bus.o_f_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
            chk("l_rvalid", bus.o_l_rvalid, m_pend >= 2);
            chk("l_rdata", bus.o_l_rdata, (m_pend == 2) ? m_pend_data : 32'h0);
            chk("busy", bus.o_busy, m_pend != 0);

            w = int'(e_addr);
            m_pend = (win == 0) ? 0 : (win == 1) ? 1 : (e_write ? 3 : 2);
            m_pend_data = shadow[w];
            if (e_write) begin
                for (int b = 0; b < 4; b++)
                    if (e_size[b]) shadow[w][8*b +: 8] = e_wdata[8*b +: 8];
            end
            if (win != 0) m_last_l = (win == 2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_f_req = 0; bus.i_l_req = 0; bus.i_l_we = 0; bus.i_l_lock = 0;
    endtask

    task automatic lreq(logic we, logic [3:0] size, logic [31:0] addr, logic [31:0] wdata);
        bus.i_l_req = 1; bus.i_l_we = we; bus.i_l_size = size;
        bus.i_l_addr = addr; bus.i_l_wdata = wdata;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_last_l = 1'b1;
        m_pend   = 0;
        m_pend_data = 0;
        mem_rdata_q = 0;
        for (int i = 0; i < Words; i++) begin
            sram[i]   = init_word(i);
            shadow[i] = init_word(i);
        end
        rst_n = 0;
        bus.i_f_addr = 0; bus.i_l_size = 0; bus.i_l_addr = 0; bus.i_l_wdata = 0;
        bus.i_l_we = 0; bus.i_l_lock = 0;
        bus.i_f_req = 1; bus.i_l_req = 1;
        @(negedge clk);
        chk("reset_gates_f_gnt", bus.o_f_gnt, 0);
        chk("reset_gates_l_gnt", bus.o_l_gnt, 0);

        // Conflict right after reset: F, L, F, L; loader read forces size F.
        cyc();
        rst_n = 1;
        bus.i_f_req = 1; bus.i_f_addr = 32'h10;
        lreq(0, 4'b0001, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("conflict_f_gnt", bus.o_f_gnt, (k % 2) == 0);
            chk("conflict_l_gnt", bus.o_l_gnt, (k % 2) == 1);
            chk("conflict_busy", bus.o_busy, k > 0);
            if (k == 1) chk("conflict_f_rdata", bus.o_f_rdata, 32'hC0DE0004);
            if (k == 1) chk("conflict_l_size", bus.o_mem_size, 4'hF);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("conflict_tail_busy", bus.o_busy, 1);
        chk("conflict_l_rdata", bus.o_l_rdata, 32'hC0DE0008);
        cyc();
        @(negedge clk);
        chk("conflict_idle_busy", bus.o_busy, 0);

        // Single fetch of 0x104.
        cyc();
        bus.i_f_req = 1; bus.i_f_addr = 32'h104;
        @(negedge clk);
        chk("fetch_gnt", bus.o_f_gnt, 1);
        chk("fetch_mem_addr", bus.o_mem_addr, 32'h041);
        chk("fetch_mem_read", bus.o_mem_read, 1);
        cyc();
        idle();
        @(negedge clk);
        chk("fetch_rvalid", bus.o_f_rvalid, 1);
        chk("fetch_rdata", bus.o_f_rdata, 32'hC0DE0041);

        // Loader halfword write, then fetch it back.
        cyc();
        lreq(1, 4'b0011, 32'h8, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_mem_write", bus.o_mem_write, 1);
        chk("lw_mem_addr", bus.o_mem_addr, 32'h002);
        chk("lw_mem_size", bus.o_mem_size, 4'b0011);
        cyc();
        idle();
        bus.i_f_req = 1; bus.i_f_addr = 32'h8;
        @(negedge clk);
        chk("lw_ack_rvalid", bus.o_l_rvalid, 1);
        chk("lw_ack_rdata", bus.o_l_rdata, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("lw_readback", bus.o_f_rdata, 32'hC0DEBEEF);

        // Lock holds off fetch for 5 cycles; loader still served under lock.
        cyc();
        bus.i_f_req = 1; bus.i_f_addr = 32'h30; bus.i_l_lock = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) lreq(0, 4'hF, 32'h34, 32'h0);
            else bus.i_l_req = 0;
            @(negedge clk);
            chk("lock_f_gnt", bus.o_f_gnt, 0);
            cyc();
        end
        bus.i_l_req = 0; bus.i_l_lock = 0;
        @(negedge clk);
        chk("unlock_f_gnt", bus.o_f_gnt, 1);
        // Lock rising after a fetch grant does not cancel its response.
        cyc();
        bus.i_f_req = 0; bus.i_l_lock = 1;
        @(negedge clk);
        chk("lock_keeps_rvalid", bus.o_f_rvalid, 1);
        chk("lock_keeps_rdata", bus.o_f_rdata, 32'hC0DE000C);
        cyc();
        idle();

        // Reset mid-operation drops the response and restores fetch priority.
        cyc();
        bus.i_f_req = 1; bus.i_f_addr = 32'h0;
        @(negedge clk);
        chk("pre_rst_f_gnt", bus.o_f_gnt, 1);
        cyc();
        bus.i_f_req = 0;
        rst_n = 0;
        @(negedge clk);
        chk("midrst_f_rvalid", bus.o_f_rvalid, 0);
        chk("midrst_busy", bus.o_busy, 0);
        cyc();
        rst_n = 1;
        bus.i_f_req = 1;
        lreq(0, 4'hF, 32'h4, 32'h0);
        @(negedge clk);
        chk("post_rst_f_first", bus.o_f_gnt, 1);
        chk("post_rst_l_wait", bus.o_l_gnt, 0);
        cyc();
        bus.i_f_req = 0;
        @(negedge clk);
        chk("post_rst_l_gnt", bus.o_l_gnt, 1);
        cyc();
        idle();

        // Address wrap beyond the SRAM window.
        cyc();
        bus.i_f_req = 1; bus.i_f_addr = 32'h0000_1004;
        @(negedge clk);
        chk("wrap_mem_addr", bus.o_mem_addr, 32'h001);
        cyc();
        idle();

        // Back-to-back loader writes then reads: one access per cycle.
        for (int k = 0; k < 8; k++) begin
            cyc();
            lreq(1, 4'hF, 32'h100 + 4 * k, 32'h5500_0000 + k);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            lreq(0, 4'hF, 32'h100 + 4 * k, 32'h0);
        end
        cyc();
        idle();
        @(negedge clk);
        chk("stream_last_rdata", bus.o_l_rdata, 32'h5500_0007);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
